// File: rtl/issue_id_allocator_if.sv
// Issue-ID allocator bus: allocation requests/grants, completions, retire status.
// ISSUE_ID_ALLOC_STATS_EN adds the stall_cycles counter output.
interface issue_id_allocator_if #(
   parameter int ID_WIDTH  = 6,
   parameter int NUM_ALLOC = 2,
   parameter int NUM_DONE  = 4
);
   localparam int RCW = $clog2(NUM_ALLOC + 1);

   logic                                flush;
   logic [NUM_ALLOC-1:0]                alloc_req;
   logic [NUM_ALLOC-1:0]                alloc_grant;
   logic [NUM_ALLOC-1:0][ID_WIDTH-1:0]  alloc_id;
   logic [NUM_DONE-1:0]                 done_valid;
   logic [NUM_DONE-1:0][ID_WIDTH-1:0]   done_id;
   logic [RCW-1:0]                      retire_count;
   logic [ID_WIDTH-1:0]                 oldest_id;
   logic [ID_WIDTH-1:0]                 inflight_cnt;
   logic                                empty;
   logic                                full;
`ifdef ISSUE_ID_ALLOC_STATS_EN
   logic [31:0]                         stall_cycles;
`endif

   modport master (
      output flush, alloc_req, done_valid, done_id,
      input  alloc_grant, alloc_id, retire_count,
      input  oldest_id, inflight_cnt, empty, full
`ifdef ISSUE_ID_ALLOC_STATS_EN
      , input stall_cycles
`endif
   );

   modport slave (
      input  flush, alloc_req, done_valid, done_id,
      output alloc_grant, alloc_id, retire_count,
      output oldest_id, inflight_cnt, empty, full
`ifdef ISSUE_ID_ALLOC_STATS_EN
      , output stall_cycles
`endif
   );
endinterface

// File: rtl/issue_id_allocator.sv
// Ring-ordered issue-ID allocator with out-of-order completion and in-order retire.
// Optional ISSUE_ID_ALLOC_STATS_EN adds a saturating capacity-stall counter.
module issue_id_allocator #(
   parameter int ID_WIDTH  = 6,
   parameter int NUM_ALLOC = 2,
   parameter int NUM_DONE  = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   issue_id_allocator_if.slave    bus
);
   localparam int RING = 1 << ID_WIDTH;
   localparam int MAXF = 1 << (ID_WIDTH - 1);
   localparam int RCW  = $clog2(NUM_ALLOC + 1);

   logic [ID_WIDTH-1:0] head_q, head_d;
   logic [ID_WIDTH-1:0] tail_q, tail_d;
   logic [ID_WIDTH-1:0] cnt_q, cnt_d;
   logic [RING-1:0]     done_q, done_d;

   logic [NUM_ALLOC-1:0]               grant;
   logic [NUM_ALLOC-1:0][ID_WIDTH-1:0] ids;
   logic [ID_WIDTH-1:0]                ngrant;
   logic [ID_WIDTH-1:0]                free;
   logic [RCW-1:0]                     ret;
   logic                               run;
   logic                               deny;

   // Flash grant: k-th granted slot gets tail+k, bounded by free window.
   always_comb begin
      free   = ID_WIDTH'(MAXF) - cnt_q;
      ngrant = '0;
      grant  = '0;
      ids    = '0;
      deny   = 1'b0;
      for (int i = 0; i < NUM_ALLOC; i++) begin
         ids[i] = tail_q + ngrant;
         if (bus.alloc_req[i] && !bus.flush && rst_n) begin
            if (ngrant < free) begin
               grant[i] = 1'b1;
               ngrant   = ngrant + ID_WIDTH'(1);
            end else begin
               deny = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ret = '0;
      run = 1'b1;
      for (int k = 0; k < NUM_ALLOC; k++) begin
         if (run && (ID_WIDTH'(k) < cnt_q) &&
             done_q[head_q + ID_WIDTH'(k)]) begin
            ret = ret + RCW'(1);
         end else begin
            run = 1'b0;
         end
      end
      if (bus.flush) ret = '0;
   end

   // Retire clears are applied after sets so a late duplicate cannot leave a stale bit.
   always_comb begin
      done_d = done_q;
      for (int j = 0; j < NUM_DONE; j++) begin
         if (bus.done_valid[j] &&
             (ID_WIDTH'(bus.done_id[j] - head_q) < cnt_q)) begin
            done_d[bus.done_id[j]] = 1'b1;
         end
      end
      for (int k = 0; k < NUM_ALLOC; k++) begin
         if (RCW'(k) < ret) done_d[head_q + ID_WIDTH'(k)] = 1'b0;
      end
      if (bus.flush) done_d = '0;
   end

   always_comb begin
      if (bus.flush) begin
         head_d = tail_q;
         tail_d = tail_q;
         cnt_d  = '0;
      end else begin
         head_d = head_q + ID_WIDTH'(ret);
         tail_d = tail_q + ngrant;
         cnt_d  = cnt_q + ngrant - ID_WIDTH'(ret);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         done_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign bus.alloc_grant  = grant;
   assign bus.alloc_id     = ids;
   assign bus.retire_count = ret;
   assign bus.oldest_id    = head_q;
   assign bus.inflight_cnt = cnt_q;
   assign bus.empty        = (cnt_q == '0);
   assign bus.full         = (cnt_q == ID_WIDTH'(MAXF));

`ifdef ISSUE_ID_ALLOC_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (deny && (stall_q != '1)) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign bus.stall_cycles = stall_q;
`else
   logic unused_deny;
   assign unused_deny = deny;
`endif
endmodule
